// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and defaults for the multicycle MIPS datapath
//
// Purpose: destination-select codes, stage encodings, default widths and the
//          register-file init FSM state type.
// Ports:   none (package).
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_LINK = 2'd2;
    localparam logic [1:0] REGDST_NONE = 2'd3;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port of the register file
//
// Purpose: selects zero (r0), the in-flight write-back value (bypass) or the
//          stored word, and registers it with one cycle of latency.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset, clears data
//   run      in   register file has finished its init sweep
//   addr     in   read address
//   commit   in   a write commits on this edge
//   dest     in   address of the committing write
//   wb_value in   value of the committing write
//   mem_data in   stored word at addr, pre-edge
//   data     out  registered read data
module rf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic              commit,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clock) begin
        if (reset || !run) begin
            data <= '0;
        end else if (addr == '0) begin
            data <= '0;
        end else if ((BYPASS != 0) && commit && (addr == dest)) begin
            // Forward the write being committed on this same edge.
            data <= wb_value;
        end else begin
            data <= mem_data;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file with integrated write-back stage
//
// Purpose: commits wb_value to rt/rd/link during the write-back stage, serves
//          NUM_RD registered read ports, and clears storage with a sweep after
//          reset so the array maps onto plain RAM.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   stage      in   current multicycle stage
//   reg_write  in   write-back enable
//   reg_dst    in   destination select (rt / rd / link / none)
//   addr_rt    in   rt field
//   addr_rd    in   rd field
//   wb_value   in   value to commit
//   rd_addr    in   packed read addresses, port i in slice i
//   rd_data    out  packed registered read data
//   ready      out  init sweep finished, writes accepted
//   wb_done    out  pulse: a write committed on the previous edge
//   wb_addr_q  out  address of the last committed write
module regfile_writeback
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int STAGE_W  = 3,
    parameter int WB_STAGE = STAGE_WB,
    parameter int LINK_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [STAGE_W-1:0]       stage,
    input  logic                     reg_write,
    input  logic [1:0]               reg_dst,
    input  logic [ADDR_W-1:0]        addr_rt,
    input  logic [ADDR_W-1:0]        addr_rd,
    input  logic [DATA_W-1:0]        wb_value,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     ready,
    output logic                     wb_done,
    output logic [ADDR_W-1:0]        wb_addr_q
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W + 1)'(NREGS - 1);

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_d;
    logic [DATA_W-1:0] mem [NREGS];

    logic [ADDR_W-1:0] dest;
    logic              commit;

    // ready tracks the RUN state exactly: both are cleared by reset and both
    // become set on the final sweep edge.
    assign ready = (state_q == RUN);

    always_comb begin
        dest = '0;
        case (reg_dst)
            REGDST_RT:   dest = addr_rt;
            REGDST_RD:   dest = addr_rd;
            REGDST_LINK: dest = ADDR_W'(LINK_REG);
            default:     dest = '0;
        endcase
    end

    // dest==0 also covers REGDST_NONE, which maps to address 0 above.
    assign commit = ready && reg_write && (stage == STAGE_W'(WB_STAGE))
                    && (reg_dst != REGDST_NONE) && (dest != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Single write port: the sweep and write-back never overlap, so one
    // address/data pair serves both and storage stays RAM-shaped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem[idx_q[ADDR_W-1:0]] <= '0;
            end else if (commit) begin
                mem[dest] <= wb_value;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_done   <= 1'b0;
            wb_addr_q <= '0;
        end else if (commit) begin
            wb_done   <= 1'b1;
            wb_addr_q <= dest;
        end else begin
            wb_done   <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_mem;

        assign port_addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign port_mem  = mem[port_addr];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .clock    (clock),
            .reset    (reset),
            .run      (ready),
            .addr     (port_addr),
            .commit   (commit),
            .dest     (dest),
            .wb_value (wb_value),
            .mem_data (port_mem),
            .data     (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  stage;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [4:0]  addr_rt;
    logic [4:0]  addr_rd;
    logic [31:0] wb_value;
    logic [9:0]  rd_addr;

    logic [63:0] rd_data_b;
    logic        ready_b;
    logic        wb_done_b;
    logic [4:0]  wb_addr_q_b;

    logic [63:0] rd_data_n;
    logic        ready_n;
    logic        wb_done_n;
    logic [4:0]  wb_addr_q_n;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    regfile_writeback #(.BYPASS(1)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .stage     (stage),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .addr_rt   (addr_rt),
        .addr_rd   (addr_rd),
        .wb_value  (wb_value),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_b),
        .ready     (ready_b),
        .wb_done   (wb_done_b),
        .wb_addr_q (wb_addr_q_b)
    );

    regfile_writeback #(.BYPASS(0)) u_dut_nb (
        .clock     (clock),
        .reset     (reset),
        .stage     (stage),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .addr_rt   (addr_rt),
        .addr_rd   (addr_rd),
        .wb_value  (wb_value),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_n),
        .ready     (ready_n),
        .wb_done   (wb_done_n),
        .wb_addr_q (wb_addr_q_n)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        stage     = 3'd0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        addr_rt   = 5'd0;
        addr_rd   = 5'd0;
        wb_value  = 32'h0;
        rd_addr   = 10'd0;

        tick();
        check("rst_ready", {63'd0, ready_b}, 64'd0);
        check("rst_wb_done", {63'd0, wb_done_b}, 64'd0);
        check("rst_wb_addr_q", {59'd0, wb_addr_q_b}, 64'd0);
        check("rst_rd_data", rd_data_b, 64'd0);
        reset   = 1'b0;
        rd_addr = {5'd3, 5'd17};

        for (int k = 1; k <= 32; k++) begin
            tick();
            check("init_ready", {63'd0, ready_b}, {63'd0, (k == 32)});
            check("init_ready_nb", {63'd0, ready_n}, {63'd0, (k == 32)});
            check("init_rd_data", rd_data_b, 64'd0);
        end

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            tick();
            check("cleared_read", rd_data_b, 64'd0);
        end

        // write r7 via rd
        rd_addr   = 10'd0;
        stage     = 3'd4;
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        addr_rd   = 5'd7;
        wb_value  = 32'hDEADBEEF;
        tick();
        check("r7_wb_done", {63'd0, wb_done_b}, 64'd1);
        check("r7_wb_addr_q", {59'd0, wb_addr_q_b}, 64'd7);
        reg_write = 1'b0;
        rd_addr   = {5'd0, 5'd7};
        tick();
        check("r7_read", rd_data_b, {32'h0, 32'hDEADBEEF});
        check("r7_wb_done_drop", {63'd0, wb_done_b}, 64'd0);
        check("r7_wb_addr_hold", {59'd0, wb_addr_q_b}, 64'd7);

        // wrong stage suppresses the write
        stage     = 3'd3;
        reg_write = 1'b1;
        addr_rd   = 5'd8;
        wb_value  = 32'd5;
        rd_addr   = 10'd0;
        tick();
        check("stage3_wb_done", {63'd0, wb_done_b}, 64'd0);
        check("stage3_wb_addr_q", {59'd0, wb_addr_q_b}, 64'd7);
        reg_write = 1'b0;
        rd_addr   = {5'd8, 5'd8};
        tick();
        check("stage3_r8", rd_data_b, 64'd0);

        // write to r0 is discarded
        stage     = 3'd4;
        reg_write = 1'b1;
        reg_dst   = 2'd0;
        addr_rt   = 5'd0;
        wb_value  = 32'h0000FFFF;
        rd_addr   = 10'd0;
        tick();
        check("r0_wb_done", {63'd0, wb_done_b}, 64'd0);
        reg_write = 1'b0;
        rd_addr   = {5'd7, 5'd0};
        tick();
        check("r0_read", rd_data_b, {32'hDEADBEEF, 32'h0});

        // reg_dst=3 never writes
        reg_write = 1'b1;
        reg_dst   = 2'd3;
        addr_rd   = 5'd7;
        addr_rt   = 5'd7;
        wb_value  = 32'h1;
        rd_addr   = 10'd0;
        tick();
        check("none_wb_done", {63'd0, wb_done_b}, 64'd0);
        reg_write = 1'b0;
        rd_addr   = {5'd0, 5'd7};
        tick();
        check("none_r7", rd_data_b, {32'h0, 32'hDEADBEEF});

        // link register
        reg_write = 1'b1;
        reg_dst   = 2'd2;
        wb_value  = 32'h00400008;
        rd_addr   = 10'd0;
        tick();
        check("link_wb_done", {63'd0, wb_done_b}, 64'd1);
        check("link_wb_addr_q", {59'd0, wb_addr_q_b}, 64'd31);
        reg_write = 1'b0;
        rd_addr   = {5'd31, 5'd31};
        tick();
        check("link_read", rd_data_b, {32'h00400008, 32'h00400008});

        // bypass versus no bypass
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        addr_rd   = 5'd9;
        wb_value  = 32'h12345678;
        rd_addr   = {5'd9, 5'd9};
        tick();
        check("bypass_on", rd_data_b, {32'h12345678, 32'h12345678});
        check("bypass_off", rd_data_n, 64'd0);
        check("bypass_off_wb_done", {63'd0, wb_done_n}, 64'd1);
        reg_write = 1'b0;
        tick();
        check("bypass_on_next", rd_data_b, {32'h12345678, 32'h12345678});
        check("bypass_off_next", rd_data_n, {32'h12345678, 32'h12345678});

        // write r5, then reset in the middle of a sweep
        reg_write = 1'b1;
        reg_dst   = 2'd0;
        addr_rt   = 5'd5;
        wb_value  = 32'd1;
        rd_addr   = 10'd0;
        tick();
        check("r5_wb_done", {63'd0, wb_done_b}, 64'd1);
        reg_write = 1'b0;
        rd_addr   = {5'd5, 5'd5};
        tick();
        check("r5_read", rd_data_b, {32'd1, 32'd1});

        reg_write = 1'b1;
        wb_value  = 32'd77;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        check("mid_sweep_ready", {63'd0, ready_b}, 64'd0);
        reset = 1'b1;
        tick();
        check("mid_reset_ready", {63'd0, ready_b}, 64'd0);
        check("mid_reset_rd", rd_data_b, 64'd0);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("resweep_ready", {63'd0, ready_b}, {63'd0, (k == 32)});
            check("resweep_wb_done", {63'd0, wb_done_b}, 64'd0);
            check("resweep_rd", rd_data_b, 64'd0);
        end
        reg_write = 1'b0;
        tick();
        check("r5_cleared", rd_data_b, 64'd0);
        check("r5_cleared_nb", rd_data_n, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
